// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory and decode-side handshake signals
// shared between the fetch unit and its environment.
interface instr_fetch_unit_if #(
    parameter int WIDTH = 32
);
    // Instruction memory side
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             imem_ack;

    // Decode/control stage side
    logic [WIDTH-1:0] instruction;
    logic [WIDTH-1:0] pc_out;
    logic             instr_valid;
    logic             instr_ready;
    logic             pcsrc;
    logic [WIDTH-1:0] branch_target;
    logic             illegal;

    // Status
    logic             halted;
    logic [1:0]       err_code;
    logic [WIDTH-1:0] instr_count;

    // The fetch unit itself
    modport master (
        output imem_req, imem_addr, instruction, pc_out, instr_valid,
               halted, err_code, instr_count,
        input  imem_rdata, imem_ack, instr_ready, pcsrc, branch_target, illegal
    );

    // Memory plus decode stage surrounding the fetch unit
    modport slave (
        input  imem_req, imem_addr, instruction, pc_out, instr_valid,
               halted, err_code, instr_count,
        output imem_rdata, imem_ack, instr_ready, pcsrc, branch_target, illegal
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests one word at PC, presents it to decode,
// and on each consumed instruction advances PC sequentially or to a branch
// target. Illegal instructions and misaligned targets stop fetch until reset.
module instr_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(3'd4);
    localparam logic [WIDTH-1:0] COUNT_INC = WIDTH'(1'b1);
    localparam logic [1:0]       ERR_NONE  = 2'b00;
    localparam logic [1:0]       ERR_ILL   = 2'b01;
    localparam logic [1:0]       ERR_ALIGN = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_out_q, pc_out_d;
    logic [1:0]       err_q, err_d;
    logic [WIDTH-1:0] count_q, count_d;

    // State and datapath registers; reset acts immediately, regardless of clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= {WIDTH{1'b0}};
            pc_out_q <= {WIDTH{1'b0}};
            err_q    <= ERR_NONE;
            count_q  <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    // Next-state logic: fetch, hold for decode, then branch/step or halt
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        err_d    = err_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d  = bus.imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = S_VALID;
                end else begin
                    state_d  = S_FETCH;
                end
            end
            S_VALID: begin
                if (bus.instr_ready) begin
                    count_d = count_q + COUNT_INC;
                    // Illegal wins over any branch request on the same instruction
                    if (bus.illegal) begin
                        err_d   = ERR_ILL;
                        state_d = S_HALT;
                    end else if (bus.pcsrc && (bus.branch_target[1:0] != 2'b00)) begin
                        err_d   = ERR_ALIGN;
                        state_d = S_HALT;
                    end else if (bus.pcsrc) begin
                        pc_d    = bus.branch_target;
                        state_d = S_FETCH;
                    end else begin
                        pc_d    = pc_q + PC_STEP;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_VALID;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control outputs come straight from the state register so no input
    // can ripple through to the memory or decode handshakes.
    assign bus.imem_req    = (state_q == S_FETCH);
    assign bus.instr_valid = (state_q == S_VALID);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.imem_addr   = pc_q;
    assign bus.instruction = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.err_code    = err_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized instruction streams compared against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.WIDTH(W)) bus ();
    instr_fetch_unit_if #(.WIDTH(W)) bus2 ();

    instr_fetch_unit #(.WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Second instance starting just below the address wrap point; it runs
    // with an always-ready memory and an always-ready sequential decoder.
    instr_fetch_unit #(.WIDTH(W), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    assign bus2.imem_ack      = bus2.imem_req;
    assign bus2.imem_rdata    = 32'h1357_9BDF;
    assign bus2.instr_ready   = 1'b1;
    assign bus2.pcsrc         = 1'b0;
    assign bus2.branch_target = 32'h0000_0000;
    assign bus2.illegal       = 1'b0;

    // Reference model: architectural view only
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [1:0]  m_err;
    bit          m_halt;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_req"},     32'(bus.imem_req),    32'd0);
        check({where, "_valid"},   32'(bus.instr_valid), 32'd0);
        check({where, "_halted"},  32'(bus.halted),      32'd0);
        check({where, "_err"},     32'(bus.err_code),    32'd0);
        check({where, "_instr"},   bus.instruction,      32'd0);
        check({where, "_pc_out"},  bus.pc_out,           32'd0);
        check({where, "_count"},   bus.instr_count,      32'd0);
        check({where, "_addr"},    bus.imem_addr,        32'd0);
    endtask

    // Mid-cycle reset pulse; an ACK offered while idle must be discarded
    task automatic do_reset;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        m_pc    = 32'h0000_0000;
        m_count = 32'd0;
        m_err   = 2'b00;
        m_halt  = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step;
        bus.imem_ack   = 1'b0;
    endtask

    // One instruction: memory answers after 'delay' cycles, decode stalls
    // 'stall' cycles, then consumes with the given branch/illegal flags.
    task automatic fetch_one(input int delay, input logic [31:0] data, input int stall,
                             input bit pcsrc, input logic [31:0] target, input bit illegal);
        logic [31:0] fetch_pc;
        fetch_pc = m_pc;
        for (int i = 0; i < delay; i++) begin
            bus.imem_ack    = 1'b0;
            bus.imem_rdata  = $urandom;
            bus.instr_ready = 1'($urandom_range(0, 1));
            check("wait_req",   32'(bus.imem_req),    32'd1);
            check("wait_addr",  bus.imem_addr,        m_pc);
            check("wait_valid", 32'(bus.instr_valid), 32'd0);
            step;
        end
        check("fetch_req",    32'(bus.imem_req),    32'd1);
        check("fetch_addr",   bus.imem_addr,        m_pc);
        check("fetch_valid",  32'(bus.instr_valid), 32'd0);
        check("fetch_count",  bus.instr_count,      m_count);
        check("fetch_halted", 32'(bus.halted),      32'd0);
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = data;
        bus.instr_ready = 1'($urandom_range(0, 1));
        step;
        bus.imem_ack = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            check("valid_valid",  32'(bus.instr_valid), 32'd1);
            check("valid_req",    32'(bus.imem_req),    32'd0);
            check("valid_instr",  bus.instruction,      data);
            check("valid_pc_out", bus.pc_out,           fetch_pc);
            check("valid_count",  bus.instr_count,      m_count);
            if (i < stall) begin
                bus.instr_ready   = 1'b0;
                bus.imem_ack      = 1'($urandom_range(0, 1));
                bus.imem_rdata    = $urandom;
                bus.pcsrc         = 1'($urandom_range(0, 1));
                bus.illegal       = 1'($urandom_range(0, 1));
                bus.branch_target = $urandom;
                step;
            end
        end
        bus.instr_ready   = 1'b1;
        bus.imem_ack      = 1'b0;
        bus.pcsrc         = pcsrc;
        bus.branch_target = target;
        bus.illegal       = illegal;
        step;
        bus.instr_ready = 1'b0;
        bus.pcsrc       = 1'b0;
        bus.illegal     = 1'b0;

        m_count = m_count + 32'd1;
        if (illegal) begin
            m_halt = 1'b1;
            m_err  = 2'b01;
        end else if (pcsrc && (target % 4 != 0)) begin
            m_halt = 1'b1;
            m_err  = 2'b10;
        end else if (pcsrc) begin
            m_pc = target;
        end else begin
            m_pc = m_pc + 32'd4;
        end

        check("post_count",  bus.instr_count,      m_count);
        check("post_err",    32'(bus.err_code),    32'(m_err));
        check("post_halted", 32'(bus.halted),      32'(m_halt));
        check("post_req",    32'(bus.imem_req),    32'(!m_halt));
        check("post_valid",  32'(bus.instr_valid), 32'd0);

        if (m_halt) begin
            for (int i = 0; i < 4; i++) begin
                bus.imem_ack      = 1'($urandom_range(0, 1));
                bus.imem_rdata    = $urandom;
                bus.instr_ready   = 1'($urandom_range(0, 1));
                bus.pcsrc         = 1'($urandom_range(0, 1));
                bus.illegal       = 1'($urandom_range(0, 1));
                bus.branch_target = $urandom;
                step;
                check("halt_halted", 32'(bus.halted),      32'd1);
                check("halt_req",    32'(bus.imem_req),    32'd0);
                check("halt_valid",  32'(bus.instr_valid), 32'd0);
                check("halt_err",    32'(bus.err_code),    32'(m_err));
                check("halt_count",  bus.instr_count,      m_count);
            end
        end
    endtask

    // Hard stop in case the sequence ever stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed and randomized sequence
    initial begin
        logic [31:0] rnd;
        int          r;

        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'h0000_0000;
        bus.instr_ready   = 1'b0;
        bus.pcsrc         = 1'b0;
        bus.branch_target = 32'h0000_0000;
        bus.illegal       = 1'b0;
        m_pc    = 32'h0000_0000;
        m_count = 32'd0;
        m_err   = 2'b00;
        m_halt  = 1'b0;

        #1;
        check_reset_outputs("por");
        step;
        step;
        rst = 1'b0;
        step;

        // Same-cycle ACK, always ready: 0, 4, 8 and count 3
        check("wrap_req0",  32'(bus2.imem_req), 32'd1);
        check("wrap_addr0", bus2.imem_addr,     32'hFFFF_FFFC);
        fetch_one(0, 32'h0000_0013, 0, 1'b0, 32'h0, 1'b0);
        check("wrap_req1",  32'(bus2.imem_req), 32'd1);
        check("wrap_addr1", bus2.imem_addr,     32'h0000_0000);
        fetch_one(0, 32'h0040_0093, 0, 1'b0, 32'h0, 1'b0);
        fetch_one(0, 32'h0000_8067, 0, 1'b0, 32'h0, 1'b0);
        check("count_three", bus.instr_count, 32'd3);

        // Delayed ACK from a fresh reset
        do_reset;
        fetch_one(3, 32'h0020_8033, 0, 1'b0, 32'h0, 1'b0);

        // Decode stall
        fetch_one(0, 32'hCAFE_0001, 5, 1'b0, 32'h0, 1'b0);

        // Aligned branch, then misaligned branch
        fetch_one(1, 32'h0000_0063, 0, 1'b1, 32'h0000_0040, 1'b0);
        check("branch_addr", bus.imem_addr, 32'h0000_0040);
        fetch_one(0, 32'h0000_0063, 0, 1'b1, 32'h0000_0042, 1'b0);

        // Illegal outranks branch
        do_reset;
        fetch_one(0, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0080, 1'b1);

        // Reset while a request is outstanding
        do_reset;
        bus.imem_ack = 1'b0;
        step;
        step;
        check("abandon_req", 32'(bus.imem_req), 32'd1);
        do_reset;
        fetch_one(0, 32'h1111_2222, 0, 1'b0, 32'h0, 1'b0);

        // Randomized instruction streams
        for (int n = 0; n < 200; n++) begin
            r   = int'($urandom_range(0, 15));
            rnd = $urandom;
            if (r == 1) begin
                rnd = {rnd[31:2], 2'b10};
            end else if (r == 2) begin
                rnd = {rnd[31:2], 2'b01};
            end else begin
                rnd = {rnd[31:2], 2'b00};
            end
            fetch_one(int'($urandom_range(0, 4)), $urandom, int'($urandom_range(0, 3)),
                      (r < 6), rnd, (r == 0));
            if (m_halt) begin
                do_reset;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter WIDTH, default 32: data and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be 0.
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RST  input  1: one clock; reset is asynchronous and active-high.
REQ-005 IMEM_REQ  output  1: fetch request to instruction memory.
REQ-006 IMEM_ADDR  output  WIDTH: byte address of the requested word; equals PC.
REQ-007 IMEM_RDATA  input  WIDTH: returned instruction word, valid only when IMEM_ACK=1.
REQ-008 IMEM_ACK  input  1: memory response strobe; may arrive in the same cycle as IMEM_REQ or any later cycle.
REQ-009 INSTRUCTION  output  WIDTH: registered instruction word for the decode/control stage.
REQ-010 PC_OUT  output  WIDTH: address from which INSTRUCTION was fetched.
REQ-011 INSTR_VALID  output  1: INSTRUCTION and PC_OUT are valid.
REQ-012 INSTR_READY  input  1: downstream consumes the instruction this cycle.
REQ-013 PCSRC  input  1: taken branch for the current instruction, sampled only at handshake.
REQ-014 BRANCH_TARGET  input  WIDTH: next PC when PCSRC=1, sampled only at handshake.
REQ-015 ILLEGAL  input  1: decoder flags the current instruction as unsupported, sampled only at handshake.
REQ-016 HALTED  output  1: fetch stopped after an error.
REQ-017 ERR_CODE  output  2: 00 none, 01 illegal instruction, 10 misaligned branch target.
REQ-018 INSTR_COUNT  output  WIDTH: number of completed handshakes since reset.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, VALID and HALT.
- IDLE -> FETCH unconditionally on the first edge after RST deasserts.
REQ-020 FETCH: IMEM_REQ=1 and IMEM_ADDR=PC.
- On IMEM_ACK=1: INSTRUCTION<=IMEM_RDATA, PC_OUT<=PC, go to VALID.
- Otherwise: stay in FETCH with PC and IMEM_ADDR held.
REQ-021 VALID: INSTR_VALID=1 and IMEM_REQ=0; INSTRUCTION and PC_OUT SHALL hold stable until handshake.
REQ-022 Handshake = VALID state and INSTR_READY=1; on handshake INSTR_COUNT SHALL increment by 1, wrapping 2^WIDTH-1 -> 0.
REQ-023 Handshake with ILLEGAL=1: go to HALT, ERR_CODE<=01, PC unchanged.
- ILLEGAL SHALL take priority over PCSRC.
REQ-024 Handshake with ILLEGAL=0, PCSRC=1, BRANCH_TARGET[1:0]!=0: go to HALT, ERR_CODE<=10.
REQ-025 Handshake with ILLEGAL=0, PCSRC=1, aligned target: PC<=BRANCH_TARGET, go to FETCH.
REQ-026 Handshake with ILLEGAL=0, PCSRC=0: PC<=PC+4 modulo 2^WIDTH (32'hFFFF_FFFC -> 32'h0000_0000), go to FETCH.
REQ-027 HALT: HALTED=1, IMEM_REQ=0, INSTR_VALID=0.
- All inputs are ignored.
- HALT SHALL be left only by RST.
REQ-028 IMEM_ACK SHALL be ignored in IDLE, VALID and HALT.
REQ-029 Latency: minimum 2 cycles per instruction (FETCH with same-cycle ACK, then VALID with INSTR_READY=1); no back-to-back fetches without a VALID cycle.
REQ-030 INSTR_VALID, IMEM_REQ and HALTED SHALL be decoded from the state register only, never combinationally from inputs.

Reset
REQ-031 RST=1 SHALL immediately force, in any state and without waiting for CLK:
- state=IDLE, PC=RESET_PC;
- INSTRUCTION=0, PC_OUT=0, INSTR_VALID=0, IMEM_REQ=0;
- HALTED=0, ERR_CODE=00, INSTR_COUNT=0.
REQ-032 Reset during FETCH SHALL abandon the outstanding request; an IMEM_ACK arriving in IDLE is discarded.

Verification
REQ-033 Reset release, memory returns ACK same cycle, INSTR_READY=1 always -> IMEM_ADDR sequence 0,4,8 on every other cycle; INSTR_COUNT=3 after the third handshake.
REQ-034 ACK delayed 3 cycles -> IMEM_REQ=1 and IMEM_ADDR=0 held for 4 cycles; INSTRUCTION=IMEM_RDATA (e.g. 32'h0020_8033) one cycle after ACK.
REQ-035 INSTR_READY=0 for 5 cycles in VALID -> INSTR_VALID, INSTRUCTION and PC_OUT stable; IMEM_REQ=0 throughout.
REQ-036 Handshake with PCSRC=1, BRANCH_TARGET=32'h40 -> next IMEM_ADDR=32'h40.
- Same with BRANCH_TARGET=32'h42 -> HALTED=1, ERR_CODE=10.
REQ-037 Handshake with ILLEGAL=1 and PCSRC=1 -> HALTED=1, ERR_CODE=01, no further IMEM_REQ.
- Then RST pulse mid-cycle -> immediate IDLE with all outputs at reset values, then fetch from RESET_PC.
REQ-038 RESET_PC=32'hFFFF_FFFC, one handshake with PCSRC=0 -> next IMEM_ADDR=32'h0000_0000.
